// File: rtl/sid_pkg.sv
// Shared SID constants and types for the audio mixer path.
// The helper applies the 4-bit master volume to a raw voice sum.
package sid_pkg;

  localparam int SID_MIX_W       = 10;
  localparam int SID_VOICE_W     = 8;
  localparam int MODEVOL_VOL_LSB = 0;
  localparam int MODEVOL_VOL_W   = 4;
  localparam int MODEVOL_3OFF    = 7;

  typedef logic [SID_MIX_W-1:0]     mix_t;
  typedef logic [SID_VOICE_W-1:0]   voice_t;
  typedef logic [MODEVOL_VOL_W-1:0] vol_t;

  // Worst case 765 * 15 >> 4 = 717, so the top 10 bits of the product never overflow.
  function automatic mix_t scale_mix(input mix_t sum, input vol_t vol);
    logic [SID_MIX_W+MODEVOL_VOL_W-1:0] prod;
    prod = (SID_MIX_W+MODEVOL_VOL_W)'(sum) * (SID_MIX_W+MODEVOL_VOL_W)'(vol);
    return prod[SID_MIX_W+MODEVOL_VOL_W-1:MODEVOL_VOL_W];
  endfunction

endpackage

// File: rtl/sid_pdm_dac.sv
// First-order sigma-delta modulator: the carry out of a 10-bit phase
// accumulator gives a pulse density of din/1024.
module sid_pdm_dac
  import sid_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SID_MIX_W-1:0] din,
  output logic                 pdm_out
);

  logic [SID_MIX_W:0] acc_reg;
  logic [SID_MIX_W:0] acc_next;
  logic               pdm_reg;

  assign acc_next = {1'b0, acc_reg[SID_MIX_W-1:0]} + {1'b0, din};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      pdm_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      pdm_reg <= acc_next[SID_MIX_W];
    end
  end

  assign pdm_out = pdm_reg;

endmodule

// File: rtl/sid_mixer.sv
// Sums the three SID voices once per SAMPLE_DIV clocks, applies master volume
// in a second stage and drives the parallel sample plus a PDM audio stream.
module sid_mixer
  import sid_pkg::*;
#(
  parameter int SAMPLE_DIV = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SID_VOICE_W-1:0] voice0,
  input  logic [SID_VOICE_W-1:0] voice1,
  input  logic [SID_VOICE_W-1:0] voice2,
  input  logic [7:0]             mode_vol,
  output logic [SID_MIX_W-1:0]   sample,
  output logic                   sample_valid,
  output logic                   pdm_out
);

  localparam int               DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0]     div_cnt_reg;
  logic [DIV_W-1:0]     div_cnt_next;
  logic                 tick;

  logic [SID_MIX_W-1:0] voice_ext [3];
  logic [SID_MIX_W-1:0] sum_next;
  logic [SID_MIX_W-1:0] sum_reg;
  vol_t                 vol_reg;
  logic                 s1_vld_reg;

  logic [SID_MIX_W-1:0] sample_reg;
  logic                 sample_valid_reg;
  logic [2:0]           unused_mode_bits;

  // With SAMPLE_DIV=1 the counter is a constant 0 and tick never drops.
  assign tick = (div_cnt_reg == DIV_LAST);

  always_comb begin
    div_cnt_next = div_cnt_reg + DIV_W'(1);
    if (tick) begin
      div_cnt_next = '0;
    end
  end

  assign voice_ext[0] = SID_MIX_W'(voice0);
  assign voice_ext[1] = SID_MIX_W'(voice1);
  assign voice_ext[2] = mode_vol[MODEVOL_3OFF] ? '0 : SID_MIX_W'(voice2);
  assign sum_next     = voice_ext[0] + voice_ext[1] + voice_ext[2];

  assign unused_mode_bits = mode_vol[6:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg      <= '0;
      sum_reg          <= '0;
      vol_reg          <= '0;
      s1_vld_reg       <= 1'b0;
      sample_reg       <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      s1_vld_reg  <= tick;
      // Volume is latched alongside the voices so both belong to the same sample.
      if (tick) begin
        sum_reg <= sum_next;
        vol_reg <= mode_vol[MODEVOL_VOL_LSB +: MODEVOL_VOL_W];
      end
      sample_valid_reg <= s1_vld_reg;
      if (s1_vld_reg) begin
        sample_reg <= scale_mix(sum_reg, vol_reg);
      end
    end
  end

  assign sample       = sample_reg;
  assign sample_valid = sample_valid_reg;

  sid_pdm_dac u_pdm (
    .clk     (clk),
    .rst     (rst),
    .din     (sample_reg),
    .pdm_out (pdm_out)
  );

endmodule

// File: tb/tb_sid_mixer.sv
// Checks sid_mixer at SAMPLE_DIV=32 and SAMPLE_DIV=1 side by side against an
// edge-counting reference model, plus directed scenarios for levels and PDM density.
module tb_sid_mixer;

  localparam int SD = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] voice0, voice1, voice2, mode_vol;
  logic [9:0] sample_o [2];
  logic       sv_o     [2];
  logic       pdm_o    [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  sid_mixer #(.SAMPLE_DIV(SD)) dut (
    .clk(clk), .rst(rst), .voice0(voice0), .voice1(voice1), .voice2(voice2),
    .mode_vol(mode_vol), .sample(sample_o[0]), .sample_valid(sv_o[0]), .pdm_out(pdm_o[0])
  );

  sid_mixer #(.SAMPLE_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .voice0(voice0), .voice1(voice1), .voice2(voice2),
    .mode_vol(mode_vol), .sample(sample_o[1]), .sample_valid(sv_o[1]), .pdm_out(pdm_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Mix level straight from the datasheet formula.
  function automatic int mix_ref(input int v0, input int v1, input int v2, input int mv);
    int s;
    s = v0 + v1 + (((mv & 8'h80) != 0) ? 0 : v2);
    return (s * (mv & 15)) / 16;
  endfunction

  // Reference model: k = edges since reset; tick edges are k = n*div, result visible one edge later.
  int divs     [2] = '{SD, 1};
  int k        [2];
  bit pend_v   [2];
  int pend_val [2];
  int exp_s    [2];
  bit exp_v    [2];
  bit zh       [2];
  bit pdm_zero [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        k[i] = 0; pend_v[i] = 1'b0; pend_val[i] = 0;
        exp_s[i] = 0; exp_v[i] = 1'b0; zh[i] = 1'b1; pdm_zero[i] = 1'b1;
      end else begin
        pdm_zero[i] = zh[i] && (exp_s[i] == 0);
        zh[i]       = pdm_zero[i];
        k[i]++;
        exp_v[i] = pend_v[i];
        if (pend_v[i]) exp_s[i] = pend_val[i];
        pend_v[i] = ((k[i] % divs[i]) == 0);
        if (pend_v[i]) pend_val[i] = mix_ref(int'(voice0), int'(voice1), int'(voice2), int'(mode_vol));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("valid%0d", i), 32'(sv_o[i]), 32'(exp_v[i]));
        check($sformatf("sample%0d", i), 32'(sample_o[i]), exp_s[i]);
        if (pdm_zero[i]) check($sformatf("pdm_zero%0d", i), 32'(pdm_o[i]), 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input int v0, input int v1, input int v2, input int mv);
    voice0 = 8'(v0); voice1 = 8'(v1); voice2 = 8'(v2); mode_vol = 8'(mv);
  endtask

  task automatic wait_strobe(output int got);
    got = -1;
    for (int c = 0; c < 4 * SD + 4; c++) begin
      @(negedge clk);
      if (sv_o[0]) begin
        got = int'(sample_o[0]);
        $display("[TB] strobe sample=%0d vol=%0d 3off=%0d", got, mode_vol[3:0], mode_vol[7]);
        return;
      end
    end
    check("strobe_timeout", 32'(sv_o[0]), 1);
  endtask

  task automatic wait_tick_edge();
    for (int c = 0; c < 2 * SD + 4; c++) begin
      @(negedge clk);
      if (pend_v[0]) return;
    end
    check("tick_timeout", 32'(pend_v[0]), 1);
  endtask

  // Called at the negedge where rst has just been dropped.
  task automatic measure_first();
    int c0 = -1;
    int c1 = -1;
    for (int c = 1; c <= 2 * SD + 4; c++) begin
      @(negedge clk);
      if (c0 < 0 && sv_o[0]) c0 = c;
      if (c1 < 0 && sv_o[1]) c1 = c;
      if (c0 >= 0 && c1 >= 0) break;
    end
    check("first_valid_div32", c0, SD + 1);
    check("first_valid_div1", c1, 2);
    $display("[TB] first strobe after reset: div32=%0d div1=%0d", c0, c1);
  endtask

  task automatic level_check(input string tag, input int exp);
    int got;
    wait_strobe(got);
    wait_strobe(got);
    check(tag, got, exp);
  endtask

  task automatic density_check(input string tag, input int exp);
    int ones0 = 0;
    int ones1 = 0;
    step(10);
    for (int c = 0; c < 1024; c++) begin
      @(negedge clk);
      ones0 += int'(pdm_o[0]);
      ones1 += int'(pdm_o[1]);
    end
    check({tag, "_div32"}, ones0, exp);
    check({tag, "_div1"}, ones1, exp);
    $display("[TB] pdm %s ones=%0d/%0d", tag, ones0, ones1);
  endtask

  initial begin
    int got, cnt;
    rst = 1'b1;
    set_in(200, 150, 99, 8'h0F);
    @(negedge clk);
    chk_en = 1'b1;
    step(2);
    rst = 1'b0;
    measure_first();

    // Full scale, strobe width and period
    set_in(255, 255, 255, 8'h0F);
    level_check("full_scale", 717);
    @(negedge clk);
    check("strobe_width", 32'(sv_o[0]), 0);
    cnt = 1;
    while (!sv_o[0] && cnt < 2 * SD) begin
      @(negedge clk);
      cnt++;
    end
    check("strobe_period", cnt, SD);

    // 3OFF
    set_in(255, 255, 255, 8'h8F);
    level_check("3off_full", 478);
    set_in(0, 0, 200, 8'h8F);
    level_check("3off_v2_only", 0);

    // Volume latched only on the tick edge
    set_in(100, 50, 10, 8'h08);
    level_check("vol8", 80);
    wait_tick_edge();
    mode_vol = 8'h00;
    wait_strobe(got);
    check("vol_after_tick", got, 80);
    wait_strobe(got);
    check("vol_next_tick", got, 0);

    // PDM density
    set_in(255, 255, 2, 8'h0B);
    level_check("vol11", 352);
    density_check("pdm352", 352);
    set_in(255, 255, 2, 8'h0F);
    level_check("vol15", 480);
    density_check("pdm480", 480);
    set_in(255, 255, 2, 8'h00);
    level_check("vol0", 0);
    density_check("pdm0", 0);

    // Reset between stage 1 and stage 2
    set_in(120, 77, 33, 8'h0C);
    level_check("pre_reset", mix_ref(120, 77, 33, 8'h0C));
    wait_tick_edge();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid32", 32'(sv_o[0]), 0);
    check("midrst_sample32", 32'(sample_o[0]), 0);
    check("midrst_valid1", 32'(sv_o[1]), 0);
    check("midrst_sample1", 32'(sample_o[1]), 0);
    measure_first();

    // Random traffic with occasional resets; the per-cycle model does the checking
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)
        set_in($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 3));
        rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
